// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the registered control sequencer: instruction classes,
// per-class opcodes, internal OP codes and the sequencer state type.
package ctrl_seq_pkg;

   // Class field sits in the top two instruction bits.
   typedef enum logic [1:0] {
      ClsI   = 2'b00,
      ClsII  = 2'b01,
      ClsIII = 2'b10,
      ClsIV  = 2'b11
   } instr_class_e;

   // typeI opcodes, bits [6:3]; 9..15 are unlisted.
   localparam logic [3:0] OpcAdd   = 4'd0;
   localparam logic [3:0] OpcAnd   = 4'd1;
   localparam logic [3:0] OpcOr    = 4'd2;
   localparam logic [3:0] OpcXor   = 4'd3;
   localparam logic [3:0] OpcNot   = 4'd4;
   localparam logic [3:0] OpcMover = 4'd5;
   localparam logic [3:0] OpcLoad  = 4'd6;
   localparam logic [3:0] OpcStore = 4'd7;
   localparam logic [3:0] OpcHalt  = 4'd8;

   // typeII opcode bit [6]: 0 BEQ, 1 BLT. typeIV bit [6]: 0 LSR, 1 RSR.
   // typeIII opcodes, bits [6:5].
   localparam logic [1:0] OpcAndi = 2'd0;
   localparam logic [1:0] OpcAddi = 2'd1;
   localparam logic [1:0] OpcSub  = 2'd2;
   localparam logic [1:0] OpcJump = 2'd3;

   // Internal OP codes; zero is reserved for "no operation".
   localparam logic [4:0] ONop   = 5'd0;
   localparam logic [4:0] OAdd   = 5'd1;
   localparam logic [4:0] OAnd   = 5'd2;
   localparam logic [4:0] OOr    = 5'd3;
   localparam logic [4:0] OXor   = 5'd4;
   localparam logic [4:0] ONot   = 5'd5;
   localparam logic [4:0] OMover = 5'd6;
   localparam logic [4:0] OLoad  = 5'd7;
   localparam logic [4:0] OStore = 5'd8;
   localparam logic [4:0] OBeq   = 5'd9;
   localparam logic [4:0] OBlt   = 5'd10;
   localparam logic [4:0] OAndi  = 5'd11;
   localparam logic [4:0] OAddi  = 5'd12;
   localparam logic [4:0] OSub   = 5'd13;
   localparam logic [4:0] OJump  = 5'd14;
   localparam logic [4:0] OLsr   = 5'd15;
   localparam logic [4:0] ORsr   = 5'd16;
   localparam logic [4:0] OHalt  = 5'd17;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StHalted  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Handshake and datapath-control bundle between the sequencer and its neighbours.
interface ctrl_seq_if #(
   parameter int unsigned INSTR_W = 9,
   parameter int unsigned REG_AW  = 3,
   parameter int unsigned IMM_W   = 5,
   parameter int unsigned OP_W    = 5,
   parameter int unsigned CNT_W   = 16
) ();
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               ready;
   logic               resume;
   logic               alu_zero;
   logic               alu_less;
   logic               mem_ack;
   logic               dec_valid;
   logic [OP_W-1:0]    op;
   logic [REG_AW-1:0]  reg_read_addr;
   logic [REG_AW-1:0]  reg_write_addr;
   logic               reg_write_en;
   logic [IMM_W-1:0]   imm;
   logic               jump;
   logic               branch_taken;
   logic               mem_req;
   logic               mem_write;
   logic               halted;
   logic               illegal_op;
   logic               mem_err;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      output instr, instr_valid, resume, alu_zero, alu_less, mem_ack,
      input  ready, dec_valid, op, reg_read_addr, reg_write_addr, reg_write_en, imm, jump,
             branch_taken, mem_req, mem_write, halted, illegal_op, mem_err, instr_count
   );

   modport slave (
      input  instr, instr_valid, resume, alu_zero, alu_less, mem_ack,
      output ready, dec_valid, op, reg_read_addr, reg_write_addr, reg_write_en, imm, jump,
             branch_taken, mem_req, mem_write, halted, illegal_op, mem_err, instr_count
   );
endinterface

// File: rtl/ctrl_seq_decode.sv
// Purely combinational field and opcode decode of one instruction word.
module ctrl_seq_decode
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned INSTR_W = 9,
   parameter int unsigned REG_AW  = 3,
   parameter int unsigned IMM_W   = 5,
   parameter int unsigned OP_W    = 5,
   parameter int unsigned ACC_REG = 1
) (
   input  logic [INSTR_W-1:0] instr_i,
   output logic [OP_W-1:0]    op_o,
   output logic [REG_AW-1:0]  rd_addr_o,
   output logic [REG_AW-1:0]  wr_addr_o,
   output logic [IMM_W-1:0]   imm_o,
   output logic               we_o,
   output logic               jump_o,
   output logic               mem_o,
   output logic               store_o,
   output logic               halt_o,
   output logic               illegal_o
);
   instr_class_e cls;
   assign cls = instr_class_e'(instr_i[INSTR_W-1 -: 2]);

   // Decode class and opcode into control fields; unlisted typeI opcodes become NOP.
   always_comb begin
      op_o      = OP_W'(ONop);
      rd_addr_o = REG_AW'(ACC_REG);
      wr_addr_o = REG_AW'(ACC_REG);
      imm_o     = '0;
      we_o      = 1'b0;
      jump_o    = 1'b0;
      mem_o     = 1'b0;
      store_o   = 1'b0;
      halt_o    = 1'b0;
      illegal_o = 1'b0;
      unique case (cls)
         ClsI: begin
            rd_addr_o = REG_AW'(instr_i[2:0]);
            case (instr_i[6:3])
               OpcAdd:   begin op_o = OP_W'(OAdd); we_o = 1'b1; end
               OpcAnd:   begin op_o = OP_W'(OAnd); we_o = 1'b1; end
               OpcOr:    begin op_o = OP_W'(OOr);  we_o = 1'b1; end
               OpcXor:   begin op_o = OP_W'(OXor); we_o = 1'b1; end
               OpcNot:   begin op_o = OP_W'(ONot); we_o = 1'b1; end
               OpcMover: begin
                  op_o      = OP_W'(OMover);
                  we_o      = 1'b1;
                  wr_addr_o = REG_AW'(instr_i[2:0]);
               end
               OpcLoad:  begin op_o = OP_W'(OLoad); mem_o = 1'b1; end
               OpcStore: begin op_o = OP_W'(OStore); mem_o = 1'b1; store_o = 1'b1; end
               OpcHalt:  begin op_o = OP_W'(OHalt); halt_o = 1'b1; end
               default:  illegal_o = 1'b1;
            endcase
         end
         ClsII: begin
            op_o      = instr_i[6] ? OP_W'(OBlt) : OP_W'(OBeq);
            rd_addr_o = REG_AW'(instr_i[5:3]);
            imm_o     = IMM_W'(instr_i[2:0]);
         end
         ClsIII: begin
            imm_o = IMM_W'(instr_i[4:0]);
            unique case (instr_i[6:5])
               OpcAndi: begin op_o = OP_W'(OAndi); we_o = 1'b1; end
               OpcAddi: begin op_o = OP_W'(OAddi); we_o = 1'b1; end
               OpcSub:  begin op_o = OP_W'(OSub);  we_o = 1'b1; end
               OpcJump: begin op_o = OP_W'(OJump); jump_o = 1'b1; end
            endcase
         end
         ClsIV: begin
            op_o      = instr_i[6] ? OP_W'(ORsr) : OP_W'(OLsr);
            rd_addr_o = REG_AW'(instr_i[5:3]);
            wr_addr_o = REG_AW'(instr_i[5:3]);
            imm_o     = IMM_W'(instr_i[2:0]);
            we_o      = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/ctrl_seq.sv
// Registered control sequencer: latches and decodes one instruction per handshake,
// sequences LOAD/STORE with a timeout, handles HALT/resume and counts retirements.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned INSTR_W     = 9,
   parameter int unsigned REG_AW      = 3,
   parameter int unsigned IMM_W       = 5,
   parameter int unsigned OP_W        = 5,
   parameter int unsigned ACC_REG     = 1,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input logic       clk_i,
   input logic       rst_ni,
   ctrl_seq_if.slave bus
);
   localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   ctrl_state_t       state_q;
   logic              dec_valid_q, we_q, jump_q, illegal_q, mem_op_q;
   logic              mem_req_q, mem_write_q, mem_err_q;
   logic [OP_W-1:0]   op_q;
   logic [REG_AW-1:0] rd_q, wr_q;
   logic [IMM_W-1:0]  imm_q;
   logic [TMO_W-1:0]  tmo_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [OP_W-1:0]   d_op;
   logic [REG_AW-1:0] d_rd, d_wr;
   logic [IMM_W-1:0]  d_imm;
   logic              d_we, d_jump, d_mem, d_store, d_halt, d_illegal;
   logic              accept, mem_done, retire;

   ctrl_seq_decode #(
      .INSTR_W (INSTR_W),
      .REG_AW  (REG_AW),
      .IMM_W   (IMM_W),
      .OP_W    (OP_W),
      .ACC_REG (ACC_REG)
   ) u_decode (
      .instr_i   (bus.instr),
      .op_o      (d_op),
      .rd_addr_o (d_rd),
      .wr_addr_o (d_wr),
      .imm_o     (d_imm),
      .we_o      (d_we),
      .jump_o    (d_jump),
      .mem_o     (d_mem),
      .store_o   (d_store),
      .halt_o    (d_halt),
      .illegal_o (d_illegal)
   );

   assign accept   = bus.instr_valid && (state_q == StRun);
   // MemAck only counts while a request is outstanding.
   assign mem_done = (state_q == StMemWait) && bus.mem_ack;
   assign retire   = (dec_valid_q && !mem_op_q) || mem_done;

   // FSM plus registered decode outputs; timeout fires on the last count without an ack.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StRun;
         dec_valid_q <= 1'b0;
         we_q        <= 1'b0;
         jump_q      <= 1'b0;
         illegal_q   <= 1'b0;
         mem_op_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_err_q   <= 1'b0;
         op_q        <= '0;
         rd_q        <= REG_AW'(ACC_REG);
         wr_q        <= REG_AW'(ACC_REG);
         imm_q       <= '0;
         tmo_q       <= '0;
      end else begin
         dec_valid_q <= accept;
         we_q        <= accept && d_we;
         jump_q      <= accept && d_jump;
         illegal_q   <= accept && d_illegal;
         if (accept) begin
            op_q     <= d_op;
            rd_q     <= d_rd;
            wr_q     <= d_wr;
            imm_q    <= d_imm;
            mem_op_q <= d_mem;
         end
         case (state_q)
            StRun: begin
               if (accept && d_mem) begin
                  state_q     <= StMemWait;
                  mem_req_q   <= 1'b1;
                  mem_write_q <= d_store;
                  tmo_q       <= '0;
               end else if (accept && d_halt) begin
                  state_q <= StHalted;
               end
            end
            StMemWait: begin
               if (bus.mem_ack) begin
                  state_q     <= StRun;
                  mem_req_q   <= 1'b0;
                  mem_write_q <= 1'b0;
               end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                  state_q     <= StRun;
                  mem_req_q   <= 1'b0;
                  mem_write_q <= 1'b0;
                  mem_err_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StHalted: begin
               if (bus.resume) state_q <= StRun;
            end
            default: state_q <= StRun;
         endcase
      end
   end

   // Saturating retired-instruction counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (retire && !(&cnt_q)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.ready          = (state_q == StRun);
   assign bus.dec_valid      = dec_valid_q;
   assign bus.op             = op_q;
   assign bus.reg_read_addr  = rd_q;
   assign bus.reg_write_addr = wr_q;
   // LOAD writes back in the ack cycle, not with DecValid.
   assign bus.reg_write_en   = we_q || (mem_done && !mem_write_q);
   assign bus.imm            = imm_q;
   assign bus.jump           = jump_q;
   assign bus.branch_taken   = dec_valid_q && (((op_q == OP_W'(OBeq)) && bus.alu_zero) ||
                                               ((op_q == OP_W'(OBlt)) && bus.alu_less));
   assign bus.mem_req        = mem_req_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.halted         = (state_q == StHalted);
   assign bus.illegal_op     = illegal_q;
   assign bus.mem_err        = mem_err_q;
   assign bus.instr_count    = cnt_q;
endmodule
